img_win_ctrl: RTL and testbench

//  Parametrised image-window controller; successor of the fixed 8x8 LCD controller.
//  - Loads an IMG_W x IMG_H image of DW-bit pixels from IROM into a local buffer.
//  - Executes host commands on a 2x2 window anchored at the cursor.
//  - On Write, streams the whole buffer to IRB. Accepts further commands after each Write.

---
 rtl/img_win_ctrl_pkg.sv | 32 +++
 rtl/img_win_ctrl_if.sv | 29 ++
 rtl/img_win_alu.sv | 74 +++++++
 rtl/img_win_ctrl.sv | 170 +++++++++++++++++
 tb/tb_img_win_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/img_win_ctrl_pkg.sv
// Shared opcodes, FSM encoding and pixel index helper
// for the image-window controller.
package img_ctrl_pkg;

    localparam logic [3:0] CMD_WRITE  = 4'd0;
    localparam logic [3:0] CMD_UP     = 4'd1;
    localparam logic [3:0] CMD_DOWN   = 4'd2;
    localparam logic [3:0] CMD_LEFT   = 4'd3;
    localparam logic [3:0] CMD_RIGHT  = 4'd4;
    localparam logic [3:0] CMD_AVG    = 4'd5;
    localparam logic [3:0] CMD_MIRX   = 4'd6;
    localparam logic [3:0] CMD_MIRY   = 4'd7;
    localparam logic [3:0] CMD_MAX    = 4'd8;
    localparam logic [3:0] CMD_MIN    = 4'd9;
    localparam logic [3:0] CMD_ROTCW  = 4'd10;
    localparam logic [3:0] CMD_ROTCCW = 4'd11;
    localparam logic [3:0] CMD_HOME   = 4'd12;

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_IDLE  = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    function automatic int unsigned pix_idx(
        input int unsigned row,
        input int unsigned col,
        input int unsigned w
    );
        return row * w + col;
    endfunction

endpackage

// File: rtl/img_win_ctrl_if.sv
// Host command, IROM and IRB signal bundle.
// master = host/memories side, slave = controller.
interface img_win_ctrl_if #(
    parameter int DW = 8,
    parameter int AW = 6
);
    logic [3:0]    cmd;
    logic          cmd_valid;
    logic [DW-1:0] IROM_Q;
    logic          IROM_EN;
    logic [AW-1:0] IROM_A;
    logic          IRB_RW;
    logic [DW-1:0] IRB_D;
    logic [AW-1:0] IRB_A;
    logic          busy;
    logic          done;

    modport master (
        output cmd, cmd_valid, IROM_Q,
        input  IROM_EN, IROM_A, IRB_RW,
        input  IRB_D, IRB_A, busy, done
    );

    modport slave (
        input  cmd, cmd_valid, IROM_Q,
        output IROM_EN, IROM_A, IRB_RW,
        output IRB_D, IRB_A, busy, done
    );
endinterface

// File: rtl/img_win_alu.sv
// Combinational 2x2 window transform.
// Opcodes that are not window ops pass pixels through.
module img_win_alu
    import img_ctrl_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [3:0]    op,
    input  logic [DW-1:0] p0,
    input  logic [DW-1:0] p1,
    input  logic [DW-1:0] p2,
    input  logic [DW-1:0] p3,
    output logic [DW-1:0] q0,
    output logic [DW-1:0] q1,
    output logic [DW-1:0] q2,
    output logic [DW-1:0] q3
);

    logic [DW+1:0] sum;
    logic [DW-1:0] avg;
    logic [DW-1:0] mx01, mx23, mx;
    logic [DW-1:0] mn01, mn23, mn;

    assign sum  = {2'b00, p0} + {2'b00, p1}
                + {2'b00, p2} + {2'b00, p3};
    assign avg  = sum[DW+1:2];
    assign mx01 = (p0 > p1) ? p0 : p1;
    assign mx23 = (p2 > p3) ? p2 : p3;
    assign mx   = (mx01 > mx23) ? mx01 : mx23;
    assign mn01 = (p0 < p1) ? p0 : p1;
    assign mn23 = (p2 < p3) ? p2 : p3;
    assign mn   = (mn01 < mn23) ? mn01 : mn23;

    // Select the new window contents for the opcode
    always_comb begin
        q0 = p0;
        q1 = p1;
        q2 = p2;
        q3 = p3;
        unique case (op)
            CMD_AVG: begin
                q0 = avg; q1 = avg;
                q2 = avg; q3 = avg;
            end
            CMD_MIRX: begin
                q0 = p2; q1 = p3;
                q2 = p0; q3 = p1;
            end
            CMD_MIRY: begin
                q0 = p1; q1 = p0;
                q2 = p3; q3 = p2;
            end
            CMD_MAX: begin
                q0 = mx; q1 = mx;
                q2 = mx; q3 = mx;
            end
            CMD_MIN: begin
                q0 = mn; q1 = mn;
                q2 = mn; q3 = mn;
            end
            CMD_ROTCW: begin
                q0 = p2; q1 = p0;
                q2 = p3; q3 = p1;
            end
            CMD_ROTCCW: begin
                q0 = p1; q1 = p3;
                q2 = p0; q3 = p2;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/img_win_ctrl.sv
// Image-window controller: loads the image from IROM,
// runs 2x2 window commands, streams the buffer to IRB.
module img_win_ctrl
    import img_ctrl_pkg::*;
#(
    parameter int DW    = 8,
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input logic         clk,
    input logic         reset,
    img_win_ctrl_if.slave bus
);

    localparam int N  = IMG_W * IMG_H;
    localparam int AW = $clog2(N);
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    localparam logic [XW-1:0] X_HOME = XW'(IMG_W / 2);
    localparam logic [YW-1:0] Y_HOME = YW'(IMG_H / 2);
    localparam logic [XW-1:0] X_MAX  = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX  = YW'(IMG_H - 1);
    localparam logic [AW-1:0] A_LAST = AW'(N - 1);

    logic [1:0]    state;
    logic [3:0]    op;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic          ld_tail;
    logic          cap_v;
    logic [AW-1:0] cap_a;
    logic [AW-1:0] irom_a;
    logic          irb_rw;
    logic [DW-1:0] irb_d;
    logic [AW-1:0] irb_a;
    logic          busy;
    logic          done;

    logic [DW-1:0] pix [N];

    logic [AW-1:0] i0, i1, i2, i3;
    logic [DW-1:0] q0, q1, q2, q3;
    logic          win_op;

    assign i0 = AW'(pix_idx(32'(cy) - 32'd1,
                            32'(cx) - 32'd1, IMG_W));
    assign i1 = AW'(pix_idx(32'(cy) - 32'd1,
                            32'(cx), IMG_W));
    assign i2 = AW'(pix_idx(32'(cy),
                            32'(cx) - 32'd1, IMG_W));
    assign i3 = AW'(pix_idx(32'(cy), 32'(cx), IMG_W));

    assign win_op = (op >= CMD_AVG) && (op <= CMD_ROTCCW);

    img_win_alu #(.DW(DW)) u_alu (
        .op (op),
        .p0 (pix[i0]),
        .p1 (pix[i1]),
        .p2 (pix[i2]),
        .p3 (pix[i3]),
        .q0 (q0),
        .q1 (q1),
        .q2 (q2),
        .q3 (q3)
    );

    // ROM is enabled from reset release until the last address
    assign bus.IROM_EN = reset | (state != S_LOAD) | ld_tail;
    assign bus.IROM_A  = irom_a;
    assign bus.IRB_RW  = irb_rw;
    assign bus.IRB_D   = irb_d;
    assign bus.IRB_A   = irb_a;
    assign bus.busy    = busy;
    assign bus.done    = done;

    // FSM, cursor and IROM/IRB sequencing
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_LOAD;
            op      <= CMD_WRITE;
            cx      <= X_HOME;
            cy      <= Y_HOME;
            ld_tail <= 1'b0;
            cap_v   <= 1'b0;
            cap_a   <= '0;
            irom_a  <= '0;
            irb_rw  <= 1'b1;
            irb_d   <= '0;
            irb_a   <= '0;
            busy    <= 1'b1;
            done    <= 1'b0;
        end else begin
            done  <= 1'b0;
            cap_v <= 1'b0;
            unique case (state)
                S_LOAD: begin
                    cap_v <= ~ld_tail;
                    cap_a <= irom_a;
                    if (ld_tail) begin
                        ld_tail <= 1'b0;
                        busy    <= 1'b0;
                        state   <= S_IDLE;
                    end else begin
                        irom_a  <= irom_a + 1'b1;
                        ld_tail <= (irom_a == A_LAST);
                    end
                end
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        op    <= bus.cmd;
                        busy  <= 1'b1;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                    unique case (op)
                        CMD_WRITE: begin
                            busy   <= 1'b1;
                            state  <= S_WRITE;
                            irb_rw <= 1'b0;
                            irb_a  <= '0;
                            irb_d  <= pix[0];
                        end
                        CMD_UP:
                            if (cy != YW'(1)) cy <= cy - 1'b1;
                        CMD_DOWN:
                            if (cy != Y_MAX) cy <= cy + 1'b1;
                        CMD_LEFT:
                            if (cx != XW'(1)) cx <= cx - 1'b1;
                        CMD_RIGHT:
                            if (cx != X_MAX) cx <= cx + 1'b1;
                        CMD_HOME: begin
                            cx <= X_HOME;
                            cy <= Y_HOME;
                        end
                        default: begin
                        end
                    endcase
                end
                S_WRITE: begin
                    if (irb_a == A_LAST) begin
                        irb_rw <= 1'b1;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        irb_a <= irb_a + 1'b1;
                        irb_d <= pix[irb_a + 1'b1];
                    end
                end
            endcase
        end
    end

    // Pixel buffer: ROM capture during load, window update on exec
    always_ff @(posedge clk) begin
        if (state == S_LOAD && cap_v) begin
            pix[cap_a] <= bus.IROM_Q;
        end else if (state == S_EXEC && win_op) begin
            pix[i0] <= q0;
            pix[i1] <= q1;
            pix[i2] <= q2;
            pix[i3] <= q3;
        end
    end

endmodule

// File: tb/tb_img_win_ctrl.sv
// Randomised self-checking bench for img_win_ctrl:
// 8x8 instance plus a 16x4 instance, image-level model.
module tb_img_win_ctrl;

    logic       clk = 1'b0;
    logic       rst_a;
    logic       rst_b;
    logic       sel;
    logic [3:0] cmd;
    logic       cmd_valid;

    always #5 clk = ~clk;

    img_win_ctrl_if #(.DW(8), .AW(6)) ifa ();
    img_win_ctrl_if #(.DW(8), .AW(6)) ifb ();

    assign ifa.cmd       = cmd;
    assign ifa.cmd_valid = cmd_valid & ~sel;
    assign ifb.cmd       = cmd;
    assign ifb.cmd_valid = cmd_valid & sel;

    img_win_ctrl #(.DW(8), .IMG_W(8), .IMG_H(8)) dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (ifa.slave)
    );

    img_win_ctrl #(.DW(8), .IMG_W(16), .IMG_H(4)) dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (ifb.slave)
    );

    logic [7:0] rom [64];
    logic [7:0] irb [64];
    logic [7:0] snap [64];

    // Synchronous ROMs, one cycle latency
    always @(posedge clk)
        if (!ifa.IROM_EN) ifa.IROM_Q <= rom[ifa.IROM_A];

    always @(posedge clk)
        if (!ifb.IROM_EN) ifb.IROM_Q <= rom[ifb.IROM_A];

    logic       cur_busy, cur_done, cur_rw, cur_en;
    logic [5:0] cur_a, cur_ia;
    logic [7:0] cur_d;

    assign cur_busy = sel ? ifb.busy    : ifa.busy;
    assign cur_done = sel ? ifb.done    : ifa.done;
    assign cur_rw   = sel ? ifb.IRB_RW  : ifa.IRB_RW;
    assign cur_en   = sel ? ifb.IROM_EN : ifa.IROM_EN;
    assign cur_a    = sel ? ifb.IRB_A   : ifa.IRB_A;
    assign cur_ia   = sel ? ifb.IROM_A  : ifa.IROM_A;
    assign cur_d    = sel ? ifb.IRB_D   : ifa.IRB_D;

    int done_tot = 0;
    int wr_tot   = 0;

    // IRB model and done pulse counter
    always @(posedge clk) begin
        if (cur_done) done_tot <= done_tot + 1;
        if (!cur_rw) begin
            irb[cur_a] <= cur_d;
            wr_tot     <= wr_tot + 1;
        end
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag,
                         input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d",
                     tag, got, exp);
        end
    endtask

    // Reference image model
    int mimg [64];
    int mx, my, mw, mh;

    function automatic int idx(input int r, input int c);
        return r * mw + c;
    endfunction

    task automatic m_exec(input int op);
        int k [4];
        int p [4];
        int q [4];
        int s;
        k[0] = idx(my - 1, mx - 1);
        k[1] = idx(my - 1, mx);
        k[2] = idx(my, mx - 1);
        k[3] = idx(my, mx);
        for (int i = 0; i < 4; i++) p[i] = mimg[k[i]];
        q = p;
        case (op)
            1: if (my > 1) my--;
            2: if (my < mh - 1) my++;
            3: if (mx > 1) mx--;
            4: if (mx < mw - 1) mx++;
            5: begin
                s = p[0] + p[1] + p[2] + p[3];
                for (int i = 0; i < 4; i++) q[i] = s / 4;
            end
            6: q = '{p[2], p[3], p[0], p[1]};
            7: q = '{p[1], p[0], p[3], p[2]};
            8: begin
                s = p[0];
                for (int i = 1; i < 4; i++)
                    if (p[i] > s) s = p[i];
                for (int i = 0; i < 4; i++) q[i] = s;
            end
            9: begin
                s = p[0];
                for (int i = 1; i < 4; i++)
                    if (p[i] < s) s = p[i];
                for (int i = 0; i < 4; i++) q[i] = s;
            end
            10: q = '{p[2], p[0], p[3], p[1]};
            11: q = '{p[1], p[3], p[0], p[2]};
            12: begin
                mx = mw / 2;
                my = mh / 2;
            end
            default: begin
            end
        endcase
        for (int i = 0; i < 4; i++) mimg[k[i]] = q[i];
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (cur_busy && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (cur_busy) check("idle_timeout", 1, 0);
    endtask

    task automatic send(input int op);
        wait_idle();
        cmd       = 4'(op);
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (op != 0) m_exec(op);
    endtask

    task automatic do_write(input string tag);
        int d0, w0, t, bad;
        d0 = done_tot;
        w0 = wr_tot;
        send(0);
        t = 0;
        while (done_tot == d0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        @(negedge clk);
        bad = 0;
        for (int k = 0; k < mw * mh; k++)
            if (int'(irb[k]) != mimg[k]) bad++;
        check({tag, "_data"}, bad, 0);
        check({tag, "_nwr"}, wr_tot - w0, mw * mh);
        check({tag, "_done"}, done_tot - d0, 1);
    endtask

    task automatic do_load(input string tag);
        int cyc, bad, na;
        if (sel) rst_b = 1'b1;
        else     rst_a = 1'b1;
        #1;
        check({tag, "_rst_en"},   cur_en, 1);
        check({tag, "_rst_ia"},   cur_ia, 0);
        check({tag, "_rst_rw"},   cur_rw, 1);
        check({tag, "_rst_d"},    cur_d, 0);
        check({tag, "_rst_a"},    cur_a, 0);
        check({tag, "_rst_busy"}, cur_busy, 1);
        check({tag, "_rst_done"}, cur_done, 0);
        @(negedge clk);
        if (sel) rst_b = 1'b0;
        else     rst_a = 1'b0;
        #1;
        cyc = 0;
        bad = 0;
        na  = 0;
        while (cyc < 300) begin
            if (!cur_en) begin
                if (cur_ia != 6'(na)) bad++;
                na++;
            end
            if (!cur_busy) break;
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_cycles"}, cyc, 65);
        check({tag, "_addr_seq"}, bad, 0);
        check({tag, "_addr_cnt"}, na, 64);
        mw = sel ? 16 : 8;
        mh = sel ? 4 : 8;
        mx = mw / 2;
        my = mh / 2;
        for (int k = 0; k < 64; k++) mimg[k] = int'(rom[k]);
    endtask

    task automatic rand_rom();
        for (int k = 0; k < 64; k++) rom[k] = 8'($urandom);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int d0, w0, t, bad;
        sel       = 1'b0;
        rst_a     = 1'b1;
        rst_b     = 1'b1;
        cmd       = 4'd0;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Load ramp and immediate write
        for (int k = 0; k < 64; k++) rom[k] = 8'(k);
        do_load("t1_load");
        do_write("t1_wr");
        check("t1_irb63", int'(irb[63]), 63);

        // Saturate to (1,1) and average
        repeat (7) send(3);
        repeat (7) send(1);
        send(5);
        do_write("t2_wr");
        check("t2_avg0", int'(irb[0]), 4);
        check("t2_avg9", int'(irb[9]), 4);

        // Mirror and rotate round trip at (4,4)
        do_load("t3_load");
        send(6);
        do_write("t3_mirx");
        check("t3_p0", int'(irb[27]), 35);
        check("t3_p3", int'(irb[36]), 28);
        send(10);
        send(11);
        do_write("t3_rot");
        check("t3_rot_p1", int'(irb[28]), 36);

        // Max / min / saturated average
        rand_rom();
        rom[27] = 8'd255;
        rom[28] = 8'd0;
        rom[35] = 8'd128;
        rom[36] = 8'd7;
        do_load("t4_load1");
        send(8);
        do_write("t4_max");
        check("t4_max", int'(irb[36]), 255);
        do_load("t4_load2");
        send(9);
        do_write("t4_min");
        check("t4_min", int'(irb[27]), 0);
        rom[28] = 8'd255;
        rom[35] = 8'd255;
        rom[36] = 8'd255;
        do_load("t4_load3");
        send(5);
        do_write("t4_avg");
        check("t4_avg", int'(irb[35]), 255);

        // Held cmd_valid executes once
        rand_rom();
        do_load("t5_load");
        wait_idle();
        cmd       = 4'd4;
        cmd_valid = 1'b1;
        @(negedge clk);
        check("t5_held_busy", cur_busy, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        m_exec(4);
        send(8);
        do_write("t5_held");

        // NOP: one busy cycle, IRB untouched
        wait_idle();
        d0        = done_tot;
        w0        = wr_tot;
        cmd       = 4'd14;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("t5_nop_busy1", cur_busy, 1);
        @(negedge clk);
        check("t5_nop_busy0", cur_busy, 0);
        check("t5_nop_wr", wr_tot - w0, 0);
        check("t5_nop_done", done_tot - d0, 0);

        // Back-to-back writes
        do_write("t5_w1");
        for (int k = 0; k < 64; k++) snap[k] = irb[k];
        do_write("t5_w2");
        bad = 0;
        for (int k = 0; k < 64; k++)
            if (snap[k] != irb[k]) bad++;
        check("t5_w_same", bad, 0);

        // Random command streams
        repeat (3) begin
            rand_rom();
            do_load("rnd_load");
            repeat (40) send(int'($urandom_range(1, 15)));
            do_write("rnd_wr");
        end

        // 16x4 instance
        rst_a = 1'b1;
        sel   = 1'b1;
        rand_rom();
        do_load("t6_load");
        repeat (10) send(4);
        send(8);
        do_write("t6_right");
        repeat (40) send(int'($urandom_range(1, 15)));
        do_write("t6_rnd");

        // Reset in the middle of a write
        send(0);
        t = 0;
        while (!(cur_rw == 1'b0 && cur_a == 6'd20)
               && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("t6_wr_k20", int'(cur_a), 20);
        rst_b = 1'b1;
        #1;
        check("t6_mid_rw", cur_rw, 1);
        check("t6_mid_busy", cur_busy, 1);
        check("t6_mid_ia", cur_ia, 0);
        do_load("t6_reload");
        send(3);
        send(7);
        do_write("t6_after");

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
